// File: rtl/maple_pkg.sv
// Shared Maple bus definitions: transmit sequencer states and frame-size constants.
package maple_pkg;

  localparam int unsigned MAPLE_HDR_BYTES       = 4;
  localparam int unsigned MAPLE_MAX_WORDS       = 255;
  localparam int unsigned MAPLE_MAX_FRAME_BYTES = MAPLE_HDR_BYTES + MAPLE_MAX_WORDS * 4 + 1;
  localparam int unsigned MAPLE_CNT_W           = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_CSUM,
    ST_END,
    ST_DRAIN,
    ST_GAP
  } maple_tx_state_t;

endpackage

// File: rtl/maple_gap_timer.sv
// Inter-frame gap timer: counts TICKS tick strobes after start, then holds expired.
module maple_gap_timer #(
  parameter int unsigned TICKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic start,
  output logic expired
);

  localparam int unsigned CW = (TICKS < 1) ? 1 : $clog2(TICKS + 1);
  localparam logic [CW-1:0] TERM = TICKS[CW-1:0];

  logic [CW-1:0] cnt;
  logic          running;

  assign expired = running && (cnt == TERM);

  // Restart on start, advance on each tick until the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      running <= 1'b1;
    end else if (running && tick && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/maple_tx_seq.sv
// Maple bus frame transmit sequencer: feeds the output stage one byte at a time,
// issues start/end triggers and enforces the inter-frame gap.
// Build option: define MAPLE_TX_CHECKSUM_EN to append the XOR checksum byte.
module maple_tx_seq
  import maple_pkg::*;
#(
  parameter int unsigned MAX_BYTES = MAPLE_MAX_FRAME_BYTES,
  parameter int unsigned GAP_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       trigger_start,
  output logic       trigger_end,
  output logic [7:0] fifo_data,
  output logic       data_avail,
  input  logic       data_consume,
  input  logic       start_active,
  input  logic       end_active,
  input  logic       oe,
  output logic       busy,
  output logic       done,
  output logic       err_overflow
);

`ifdef MAPLE_TX_CHECKSUM_EN
  localparam int unsigned HOST_LIMIT = MAX_BYTES - 1;
`else
  localparam int unsigned HOST_LIMIT = MAX_BYTES;
`endif
  localparam logic [MAPLE_CNT_W-1:0] LIMIT_CNT = HOST_LIMIT[MAPLE_CNT_W-1:0];

  maple_tx_state_t        state, state_n;
  logic [7:0]             hold;
  logic                   hold_valid;
  logic [MAPLE_CNT_W-1:0] byte_cnt;
  logic [MAPLE_CNT_W-1:0] cnt_inc;
  logic                   last_seen;
  logic                   load;
  logic                   consume;
  logic                   hit_limit;
  logic                   leave_stream;
  logic                   gap_start;
  logic                   gap_expired;

  assign in_ready     = (state == ST_STREAM) && !last_seen && (!hold_valid || data_consume);
  assign load         = in_valid && in_ready;
  assign consume      = hold_valid && data_consume;
  assign cnt_inc      = byte_cnt + 1'b1;
  assign hit_limit    = (cnt_inc == LIMIT_CNT);
  // Only the final host byte may end the stream; an empty holding register
  // without last_seen is a host stall, not end of frame.
  assign leave_stream = (state == ST_STREAM) && last_seen && (!hold_valid || consume);
  assign fifo_data    = hold;
  assign data_avail   = hold_valid;
  assign busy         = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state and trigger/done pulse decode.
  always_comb begin
    state_n       = state;
    trigger_start = 1'b0;
    trigger_end   = 1'b0;
    done          = 1'b0;
    gap_start     = 1'b0;
    case (state)
      ST_IDLE:   if (in_valid) state_n = ST_START;
      ST_START: begin
        trigger_start = 1'b1;
        state_n       = ST_STREAM;
      end
      ST_STREAM: if (leave_stream) begin
`ifdef MAPLE_TX_CHECKSUM_EN
        state_n = ST_CSUM;
`else
        state_n = ST_END;
`endif
      end
      ST_CSUM:   if (consume) state_n = ST_END;
      ST_END:    if (!start_active) begin
        trigger_end = 1'b1;
        state_n     = ST_DRAIN;
      end
      ST_DRAIN:  if (!end_active && !oe) begin
        gap_start = 1'b1;
        state_n   = ST_GAP;
      end
      ST_GAP:    if (gap_expired) begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default:   state_n = ST_IDLE;
    endcase
  end

  // Byte counter, end-of-frame flag and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt     <= '0;
      last_seen    <= 1'b0;
      err_overflow <= 1'b0;
    end else if (state == ST_START) begin
      byte_cnt     <= '0;
      last_seen    <= 1'b0;
      err_overflow <= 1'b0;
    end else if (load) begin
      byte_cnt <= cnt_inc;
      if (in_last || hit_limit) last_seen <= 1'b1;
      if (hit_limit && !in_last) err_overflow <= 1'b1;
    end
  end

`ifdef MAPLE_TX_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of accepted host bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  csum <= '0;
    else if (state == ST_START)  csum <= '0;
    else if (load)               csum <= csum ^ in_data;
  end
`endif

  // One-byte holding register presented to the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (load) begin
      hold       <= in_data;
      hold_valid <= 1'b1;
`ifdef MAPLE_TX_CHECKSUM_EN
    end else if (leave_stream) begin
      hold       <= csum;
      hold_valid <= 1'b1;
`endif
    end else if (consume) begin
      hold_valid <= 1'b0;
    end
  end

  maple_gap_timer #(
    .TICKS (GAP_TICKS)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .start   (gap_start),
    .expired (gap_expired)
  );

endmodule

// File: tb/tb_maple_tx_seq.sv
// Self-checking bench for maple_tx_seq with a behavioural output-stage model.
// Honours MAPLE_TX_CHECKSUM_EN the same way the design does.
module tb_maple_tx_seq;

  localparam int unsigned MAXB    = 8;
  localparam int unsigned GAP     = 8;
  localparam int          END_LEN = 2;
`ifdef MAPLE_TX_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
  localparam int LIMIT   = MAXB - 1;
`else
  localparam bit CSUM_ON = 1'b0;
  localparam int LIMIT   = MAXB;
`endif

  logic       clk, rst_n, tick;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic       trigger_start, trigger_end;
  logic [7:0] fifo_data;
  logic       data_avail, data_consume;
  logic       start_active, end_active, oe;
  logic       busy, done, err_overflow;

  maple_tx_seq #(
    .MAX_BYTES (MAXB),
    .GAP_TICKS (GAP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .trigger_start (trigger_start),
    .trigger_end   (trigger_end),
    .fifo_data     (fifo_data),
    .data_avail    (data_avail),
    .data_consume  (data_consume),
    .start_active  (start_active),
    .end_active    (end_active),
    .oe            (oe),
    .busy          (busy),
    .done          (done),
    .err_overflow  (err_overflow)
  );

  typedef struct { logic [7:0] d; bit last; } hbyte_t;
  typedef struct { int len; bit ovf; } frame_t;

  hbyte_t     host_q[$];
  logic [7:0] exp_q[$];
  frame_t     frame_q[$];
  int         fb_cnt = 0;
  logic [7:0] fcs = '0;
  int         chk_total = 0;
  int         chk_pass = 0;
  int         start_len = 2;
  bit         cons_in_start = 1'b0;
  int         cons_pct = 100;
  int         cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    chk_total++;
    if (got == exp) chk_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Queue a host byte and extend the scoreboard with what the output stage must see.
  task automatic host_push(input logic [7:0] d, input bit last);
    hbyte_t h;
    frame_t f;
    h.d = d;
    h.last = last;
    host_q.push_back(h);
    exp_q.push_back(d);
    fb_cnt++;
    fcs ^= d;
    if (last || fb_cnt == LIMIT) begin
      if (CSUM_ON) exp_q.push_back(fcs);
      f.len = fb_cnt + (CSUM_ON ? 1 : 0);
      f.ovf = !last;
      frame_q.push_back(f);
      fb_cnt = 0;
      fcs = '0;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((frame_q.size() != 0 || host_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_quiet();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_trigger_start", trigger_start, 0);
    check("rst_trigger_end", trigger_end, 0);
    check("rst_data_avail", data_avail, 0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_done", done, 0);
    check("rst_err_overflow", err_overflow, 0);
  endtask

  // Bit-rate strobe: one cycle in every four.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tick = (cyc % 4 == 0);
    end
  end

  // Host byte source.
  initial begin : host
    bit acc;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    forever begin
      @(negedge clk);
      acc = rst_n && in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
      end else begin
        if (acc && host_q.size() > 0) void'(host_q.pop_front());
        if (host_q.size() > 0) begin
          in_valid = 1'b1;
          in_data  = host_q[0].d;
          in_last  = host_q[0].last;
        end else begin
          in_valid = 1'b0;
          in_data  = '0;
          in_last  = 1'b0;
        end
      end
    end
  end

  // Output-stage model and scoreboard checker.
  initial begin : stage
    int start_left, end_left, gap_ticks, n_starts, n_ends, n_took;
    bit gap_on, err_chk, sa_n, ea_n, oe_n;
    frame_t f;
    logic [7:0] e;
    start_left = 0; end_left = 0; gap_ticks = 0;
    n_starts = 0; n_ends = 0; n_took = 0;
    gap_on = 0; err_chk = 0; sa_n = 0; ea_n = 0; oe_n = 0;
    start_active = 1'b0;
    end_active   = 1'b0;
    oe           = 1'b0;
    data_consume = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        start_left = 0; end_left = 0; gap_ticks = 0;
        n_starts = 0; n_ends = 0; n_took = 0;
        gap_on = 0; err_chk = 0; sa_n = 0; ea_n = 0; oe_n = 0;
      end else begin
        sa_n = start_active;
        ea_n = end_active;
        oe_n = oe;
        if (err_chk) begin
          check("err_clear", err_overflow, 0);
          err_chk = 0;
        end
        if (data_avail && data_consume) begin
          n_took++;
          if (exp_q.size() == 0) check("byte_extra", fifo_data, -1);
          else begin
            e = exp_q.pop_front();
            check("fifo_byte", fifo_data, e);
          end
        end
        if (gap_on && tick) gap_ticks++;
        if (trigger_start) begin
          n_starts++;
          sa_n = 1; oe_n = 1;
          start_left = start_len;
          err_chk = 1;
        end else if (start_active && tick) begin
          start_left--;
          if (start_left <= 0) sa_n = 0;
        end
        if (trigger_end) begin
          check("end_order", start_active, 0);
          n_ends++;
          sa_n = 0; ea_n = 1;
          end_left = END_LEN;
        end else if (end_active && tick) begin
          end_left--;
          if (end_left <= 0) begin
            ea_n = 0; oe_n = 0;
            gap_on = 1; gap_ticks = 0;
          end
        end
        if (done) begin
          if (frame_q.size() == 0) check("frame_extra", 1, 0);
          else begin
            f = frame_q.pop_front();
            check("frame_len", n_took, f.len);
            check("frame_ovf", err_overflow, int'(f.ovf));
          end
          check("start_pulses", n_starts, 1);
          check("end_pulses", n_ends, 1);
          check("gap_ticks", gap_ticks, GAP);
          n_took = 0; n_starts = 0; n_ends = 0; gap_on = 0;
        end
      end
      @(posedge clk);
      #1;
      start_active = sa_n;
      end_active   = ea_n;
      oe           = oe_n;
      data_consume = rst_n && data_avail && oe && !end_active &&
                     (!start_active || cons_in_start) &&
                     ($urandom_range(99) < cons_pct);
    end
  end

  initial begin : main
    int sent, len, n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_quiet();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Basic four-byte frame.
    host_push(8'h01, 0);
    host_push(8'h02, 0);
    host_push(8'h03, 0);
    host_push(8'h04, 1);
    wait_idle("wait_basic", 2000);

    // One-byte frame with a long start pattern; data taken during it.
    start_len = 28;
    cons_in_start = 1'b1;
    host_push(8'hA5, 1);
    wait_idle("wait_long_start", 3000);
    start_len = 2;
    cons_in_start = 1'b0;

    // Ten bytes without in_last overflow the frame; surplus starts the next one.
    for (int i = 0; i < 10; i++) host_push(8'(8'h10 + i), 0);
    host_push(8'h1A, 1);
    wait_idle("wait_overflow", 4000);

    // 64 random bytes in short frames under random back-pressure.
    cons_pct = 40;
    sent = 0;
    while (sent < 64) begin
      len = int'($urandom_range(6, 1));
      if (len > 64 - sent) len = 64 - sent;
      for (int j = 0; j < len; j++) host_push(8'($urandom), j == len - 1);
      sent += len;
    end
    wait_idle("wait_random", 20000);
    cons_pct = 100;

    // Asynchronous reset while streaming.
    for (int i = 0; i < 6; i++) host_push(8'(8'h60 + i), i == 5);
    n = 0;
    while (!data_avail && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_stream", int'(n < 200), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_quiet();
    host_q.delete();
    exp_q.delete();
    frame_q.delete();
    fb_cnt = 0;
    fcs = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Recovery frame after reset.
    host_push(8'h5A, 0);
    host_push(8'hC3, 1);
    wait_idle("wait_recover", 2000);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
